// File: rtl/btb_if.sv
// btb_if: prediction lookup and EX branch resolution bundle between the pipeline and the BTB
interface btb_if;
    logic [31:0] if_pc, pred_target, ex_pc, ex_imm32, ex_pred_target, redirect_pc;
    logic        pred_hit, pred_taken, ex_valid, ex_is_branch, ex_taken, ex_pred_taken, flush;
    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_imm32, ex_taken, ex_pred_taken, ex_pred_target,
        input  pred_hit, pred_taken, pred_target, flush, redirect_pc
    );
    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_imm32, ex_taken, ex_pred_taken, ex_pred_target,
        output pred_hit, pred_taken, pred_target, flush, redirect_pc
    );
endinterface

// File: rtl/btb_branch_unit.sv
// btb_branch_unit: direct-mapped BTB with 2-bit counters; resolves EX branches and flags mispredicts
module btb_branch_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input logic clk,
    input logic rst_n,
    btb_if.slave bus
);
    localparam int TW = 30 - IDX_W;
    logic              valid  [ENTRIES];
    logic [TW-1:0]     tag    [ENTRIES];
    logic [31:0]       target [ENTRIES];
    logic [1:0]        ctr    [ENTRIES];
    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic [TW-1:0]     if_tag, ex_tag;
    logic [31:0]       ex_target, ex_fallthru;
    logic              res, mis, ex_hit;
    logic [1:0]        ctr_n;
    always_comb begin
        if_idx          = bus.if_pc[IDX_W+1:2];
        if_tag          = bus.if_pc[31:IDX_W+2];
        bus.pred_hit    = valid[if_idx] && tag[if_idx] == if_tag;
        bus.pred_taken  = bus.pred_hit && ctr[if_idx][1];
        bus.pred_target = bus.pred_taken ? target[if_idx] : bus.if_pc + 32'd4;
        ex_idx          = bus.ex_pc[IDX_W+1:2];
        ex_tag          = bus.ex_pc[31:IDX_W+2];
        ex_target       = bus.ex_pc + bus.ex_imm32;
        ex_fallthru     = bus.ex_pc + 32'd4;
        res             = bus.ex_valid && bus.ex_is_branch;
        mis             = (bus.ex_taken != bus.ex_pred_taken) ||
                          (bus.ex_taken && bus.ex_pred_target != ex_target);
        ex_hit          = valid[ex_idx] && tag[ex_idx] == ex_tag;
        ctr_n           = bus.ex_taken ? (ctr[ex_idx] == 2'b11 ? 2'b11 : ctr[ex_idx] + 2'd1)
                                       : (ctr[ex_idx] == 2'b00 ? 2'b00 : ctr[ex_idx] - 2'd1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.flush       <= 1'b0;
            bus.redirect_pc <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= '0;
            end
        end else begin
            bus.flush <= res && mis;
            if (res && mis)
                bus.redirect_pc <= bus.ex_taken ? ex_target : ex_fallthru;
            // Hits train in place; only taken misses allocate, evicting any alias
            if (res && ex_hit) begin
                ctr[ex_idx] <= ctr_n;
                if (bus.ex_taken)
                    target[ex_idx] <= ex_target;
            end else if (res && bus.ex_taken) begin
                valid[ex_idx]  <= 1'b1;
                tag[ex_idx]    <= ex_tag;
                target[ex_idx] <= ex_target;
                ctr[ex_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_btb_branch_unit.sv
// tb_btb_branch_unit: directed checks of prediction, training, flush/redirect, aliasing and reset
module tb_btb_branch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    btb_if bus();
    btb_branch_unit #(.ENTRIES(16), .IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, got, exp);
        end
    endtask
    task automatic resolve(input logic [31:0] pc, input logic [31:0] imm, input logic tk,
                           input logic ptk, input logic [31:0] ptgt, input logic br);
        bus.ex_valid = 1'b1;
        bus.ex_is_branch = br;
        bus.ex_pc = pc;
        bus.ex_imm32 = imm;
        bus.ex_taken = tk;
        bus.ex_pred_taken = ptk;
        bus.ex_pred_target = ptgt;
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
    endtask
    task automatic pred(input string t, input logic [31:0] pc, input logic h, input logic tk,
                        input logic [31:0] tgt);
        bus.if_pc = pc;
        #1;
        chk({t, "_hit"}, {31'd0, bus.pred_hit}, {31'd0, h});
        chk({t, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, tk});
        chk({t, "_target"}, bus.pred_target, tgt);
    endtask
    task automatic fl(input string t, input logic f, input logic [31:0] rpc);
        chk({t, "_flush"}, {31'd0, bus.flush}, {31'd0, f});
        if (f) chk({t, "_redirect"}, bus.redirect_pc, rpc);
    endtask
    initial begin
        bus.if_pc = 32'h100;
        bus.ex_valid = 1'b0;
        bus.ex_is_branch = 1'b0;
        bus.ex_pc = '0;
        bus.ex_imm32 = '0;
        bus.ex_taken = 1'b0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pred_target = '0;
        #12;
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_redirect", bus.redirect_pc, 32'h0);
        pred("rst_pred", 32'h100, 0, 0, 32'h104);
        @(negedge clk);
        rst_n = 1'b1;
        // first taken resolution allocates with ctr=2 and mispredicts
        resolve(32'h100, 32'h20, 1, 0, 0, 1);
        fl("alloc", 1, 32'h120);
        resolve(32'h0, 32'h0, 0, 0, 0, 0);
        fl("idle", 0, 0);
        pred("p100a", 32'h100, 1, 1, 32'h120);
        for (int i = 0; i < 4; i++) begin
            resolve(32'h100, 32'h20, 1, 1, 32'h120, 1);
            fl("sat_taken", 0, 0);
        end
        resolve(32'h100, 32'h20, 0, 1, 32'h120, 1);
        fl("sat_nt1", 1, 32'h104);
        pred("p100_ctr2", 32'h100, 1, 1, 32'h120);
        resolve(32'h100, 32'h20, 0, 0, 32'h104, 1);
        fl("sat_nt2", 0, 0);
        pred("p100_ctr1", 32'h100, 1, 0, 32'h104);
        // alias at index 0 with a different tag
        pred("p140_miss", 32'h140, 0, 0, 32'h144);
        resolve(32'h140, 32'h10, 0, 0, 0, 1);
        fl("alias_nt", 0, 0);
        pred("p100_kept", 32'h100, 1, 0, 32'h104);
        resolve(32'h140, 32'h10, 1, 0, 0, 1);
        fl("alias_tk", 1, 32'h150);
        pred("p100_evict", 32'h100, 0, 0, 32'h104);
        pred("p140_hit", 32'h140, 1, 1, 32'h150);
        // non-branch resolution must neither flush nor allocate
        resolve(32'h380, 32'h40, 1, 0, 0, 0);
        fl("nonbr", 0, 0);
        pred("p380_miss", 32'h380, 0, 0, 32'h384);
        // negative offset, correctly predicted
        resolve(32'h200, 32'hFFFF_FFF0, 1, 1, 32'h1F0, 1);
        fl("neg", 0, 0);
        pred("p200", 32'h200, 1, 1, 32'h1F0);
        resolve(32'h200, 32'hFFFF_FFF0, 0, 1, 32'h1F0, 1);
        fl("neg_nt", 1, 32'h204);
        pred("p200_ctr1", 32'h200, 1, 0, 32'h204);
        // lookup during an update on the same index sees pre-update contents
        @(negedge clk);
        bus.if_pc = 32'h300;
        bus.ex_valid = 1'b1;
        bus.ex_is_branch = 1'b1;
        bus.ex_pc = 32'h300;
        bus.ex_imm32 = 32'h8;
        bus.ex_taken = 1'b1;
        bus.ex_pred_taken = 1'b0;
        #1;
        chk("nobypass_hit", {31'd0, bus.pred_hit}, 32'd0);
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        fl("p300", 1, 32'h308);
        pred("p300_after", 32'h300, 1, 1, 32'h308);
        // wraparound target
        resolve(32'hFFFF_FFFC, 32'h8, 1, 0, 0, 1);
        fl("wrap", 1, 32'h4);
        pred("pwrap", 32'hFFFF_FFFC, 1, 1, 32'h4);
        // reset coincident with a mispredicting resolution
        @(negedge clk);
        bus.ex_valid = 1'b1;
        bus.ex_is_branch = 1'b1;
        bus.ex_pc = 32'h100;
        bus.ex_imm32 = 32'h20;
        bus.ex_taken = 1'b1;
        bus.ex_pred_taken = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst2_redirect", bus.redirect_pc, 32'h0);
        bus.ex_valid = 1'b0;
        pred("rst2_p100", 32'h100, 0, 0, 32'h104);
        pred("rst2_pwrap", 32'hFFFF_FFFC, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fl("post_rst", 0, 0);
        pred("post_rst_p100", 32'h100, 0, 0, 32'h104);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_branch_unit.md
Name: btb_branch_unit

Overview:
- Branch target buffer and branch resolution unit for the RISC-V pipeline.
- Sits directly downstream of the immediate sign-extension stage. It consumes the extended branch offset (imm32 for Extop=2'b10: sign-extended, already shifted left 2) and forms the branch target as ex_pc + ex_imm32.
- Resolves each branch in EX, trains a direct-mapped table of 2-bit saturating counters and targets, and provides same-cycle taken/target prediction to IF.

Parameters:
- ENTRIES, 16, number of table entries; must be a power of 2 and at least 2.
- IDX_W, 4, log2(ENTRIES).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  fetch PC to predict.
- pred_hit  out  1  if_pc matches a valid entry (combinational).
- pred_taken  out  1  predicted taken (combinational).
- pred_target  out  32  predicted next PC (combinational).
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm32  in  32  sign-extended, pre-shifted branch offset.
- ex_taken  in  1  actual branch outcome.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  32  predicted next PC carried down the pipe.
- flush  out  1  registered one-cycle pulse: mispredict, squash younger stages.
- redirect_pc  out  32  registered correct next PC; meaningful when flush=1.

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. PC bits [1:0] are ignored.
- Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Reset (async, rst_n=0):
  - All valid bits and ctr cleared to 0; target and tag cleared to 0.
  - flush=0, redirect_pc=0.
  - Reset asserted mid-operation discards any in-flight update or flush.
- Lookup is combinational off the registered table:
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4.
  - After reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Target arithmetic:
  - ex_target = ex_pc + ex_imm32, 32-bit, wraps mod 2^32.
  - ex_fallthru = ex_pc + 4, also wraps.
- Resolution happens when ex_valid && ex_is_branch; otherwise nothing updates and flush=0 next cycle.
  - mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target).
  - Next edge: flush <= mispredict; redirect_pc <= ex_taken ? ex_target : ex_fallthru.
  - flush is high for exactly one cycle per mispredicting branch. It is held high on consecutive cycles only if consecutive EX branches each mispredict.
  - With no mispredict, redirect_pc holds its previous value.
- Table update, at the same edge, on resolution:
  - Hit, taken: ctr saturating increment (3 stays 3); target <= ex_target.
  - Hit, not taken: ctr saturating decrement (0 stays 0); target unchanged.
  - Miss, taken: allocate and overwrite the entry: valid=1, tag=ex tag, target=ex_target, ctr=2'b10.
  - Miss, not taken: no allocation, table unchanged.
- Same-cycle lookup and update on the same index: the lookup returns the pre-update contents. There is no write-through bypass.
- The block does not stall. It accepts one resolution per cycle.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; flush=0, redirect_pc=0.
- Resolve ex_pc=0x100, ex_imm32=0x20, ex_taken=1, ex_pred_taken=0 -> next cycle flush=1, redirect_pc=0x120. The cycle after, flush=0. if_pc=0x100 -> pred_hit=1, pred_taken=1, pred_target=0x120.
- Negative offset: ex_pc=0x200, ex_imm32=0xFFFFFFF0, taken, ex_pred_taken=1, ex_pred_target=0x1F0 -> no flush; the entry for 0x200 is allocated with target 0x1F0 and ctr=2.
- Saturation: four taken resolutions at 0x100 -> ctr=3. Then one not-taken with ex_pred_taken=1 -> flush=1, redirect_pc=0x104, ctr=2, and if_pc=0x100 still predicts taken. One more not-taken -> ctr=1, prediction becomes not-taken with pred_target=0x104.
- Aliasing: with 0x100 trained, if_pc=0x140 (same index 0, different tag) -> pred_hit=0. Resolving 0x140 not-taken leaves the 0x100 entry intact. Resolving 0x140 taken replaces it, and afterwards 0x100 misses.
- Wrap and reset: ex_pc=0xFFFFFFFC, ex_imm32=0x8, taken, mispredicted -> redirect_pc=0x00000004. Asserting rst_n=0 in the same cycle as a mispredicting resolution -> flush=0 and the table stays empty.
